// File: rtl/max2bitset_pkg.sv
// Shared types and the two-hot successor function for the sequence generator/checker pair.
package max2bitset_pkg;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NOT2HOT = 2'd1,
    ERR_SEQ     = 2'd2
  } err_e;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_e;

  typedef struct packed {
    int unsigned left;
    int unsigned right;
  } idx_pair_t;

  // Next ascending two-hot value; only meaningful for a legal pair with left > right.
  function automatic idx_pair_t succ(input int unsigned left, input int unsigned right,
                                     input int unsigned bw);
    idx_pair_t nxt;
    if (right == left - 1) begin
      if (left == bw - 1) begin
        nxt.left  = 1;
        nxt.right = 0;
      end else begin
        nxt.left  = left + 1;
        nxt.right = 0;
      end
    end else begin
      nxt.left  = left;
      nxt.right = right + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/max2bitset_seq_checker_if.sv
// Input word channel and result channel of the two-hot sequence checker.
interface max2bitset_seq_checker_if #(
  parameter int unsigned BW_NUM = 4
) ();
  import max2bitset_pkg::*;

  localparam int unsigned IW = $clog2(BW_NUM);

  logic              in_valid;
  logic              in_ready;
  logic [BW_NUM-1:0] in_num;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     out_left;
  logic [IW-1:0]     out_right;
  err_e              out_err;
  logic              out_wrap;

  modport master (
    output in_valid, in_num, out_ready,
    input  in_ready, out_valid, out_left, out_right, out_err, out_wrap
  );

  modport slave (
    input  in_valid, in_num, out_ready,
    output in_ready, out_valid, out_left, out_right, out_err, out_wrap
  );
endinterface

// File: rtl/max2bitset_seq_checker_two_hot_decode.sv
// Combinational popcount==2 check with upper/lower set-bit index extraction.
module two_hot_decode #(
  parameter  int unsigned BW_NUM = 4,
  localparam int unsigned IW     = $clog2(BW_NUM)
) (
  input  logic [BW_NUM-1:0] num,
  output logic              two_hot,
  output logic [IW-1:0]     left,
  output logic [IW-1:0]     right
);
  localparam int unsigned CW = $clog2(BW_NUM + 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] msb;
  logic [IW-1:0] lsb;

  always_comb begin
    cnt = '0;
    msb = '0;
    lsb = '0;
    for (int i = 0; i < int'(BW_NUM); i++) begin
      if (num[i]) begin
        cnt = cnt + CW'(1);
        msb = IW'(i);
      end
    end
    for (int i = int'(BW_NUM) - 1; i >= 0; i--) begin
      if (num[i]) begin
        lsb = IW'(i);
      end
    end
    two_hot = (cnt == CW'(2));
    left    = two_hot ? msb : '0;
    right   = two_hot ? lsb : '0;
  end
endmodule

// File: rtl/max2bitset_seq_checker.sv
// Checks that accepted words follow the ascending two-hot sequence; registered results + counters.
module max2bitset_seq_checker
  import max2bitset_pkg::*;
#(
  parameter int unsigned BW_NUM = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_b,
  max2bitset_seq_checker_if.slave bus,
  output logic                  locked,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      wrap_cnt
);
  localparam int unsigned IW = $clog2(BW_NUM);

  logic          accept;
  logic          dec_two_hot;
  logic [IW-1:0] dec_left;
  logic [IW-1:0] dec_right;
  logic          wrap_d;
  err_e          err_d;
  idx_pair_t     nxt;

  state_e        state_q, state_d;
  logic [IW-1:0] exp_l_q, exp_l_d;
  logic [IW-1:0] exp_r_q, exp_r_d;

  logic          out_valid_q;
  logic [IW-1:0] out_left_q;
  logic [IW-1:0] out_right_q;
  err_e          out_err_q;
  logic          out_wrap_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] wrap_cnt_q;

  two_hot_decode #(
    .BW_NUM (BW_NUM)
  ) u_decode (
    .num     (bus.in_num),
    .two_hot (dec_two_hot),
    .left    (dec_left),
    .right   (dec_right)
  );

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign wrap_d       = dec_two_hot && (dec_left == IW'(BW_NUM - 1))
                        && (dec_right == IW'(BW_NUM - 2));

  always_comb begin
    state_d = state_q;
    exp_l_d = exp_l_q;
    exp_r_d = exp_r_q;
    err_d   = ERR_NONE;
    nxt     = succ(32'(dec_left), 32'(dec_right), BW_NUM);
    if (accept) begin
      if (!dec_two_hot) begin
        err_d   = ERR_NOT2HOT;
        state_d = SYNC;
      end else begin
        unique case (state_q)
          SYNC: begin
            if (dec_left == IW'(1) && dec_right == IW'(0)) begin
              state_d = TRACK;
              exp_l_d = IW'(nxt.left);
              exp_r_d = IW'(nxt.right);
            end else begin
              err_d = ERR_SEQ;
            end
          end
          TRACK: begin
            if (dec_left != exp_l_q || dec_right != exp_r_q) begin
              err_d = ERR_SEQ;
            end
            // Resync on mismatch so one bad word produces one error, not a burst.
            exp_l_d = IW'(nxt.left);
            exp_r_d = IW'(nxt.right);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    locked = (state_q == TRACK);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= SYNC;
      exp_l_q     <= IW'(1);
      exp_r_q     <= '0;
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_err_q   <= ERR_NONE;
      out_wrap_q  <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_l_q <= exp_l_d;
      exp_r_q <= exp_r_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_left_q  <= dec_left;
        out_right_q <= dec_right;
        out_err_q   <= err_d;
        out_wrap_q  <= wrap_d;
        if (err_d != ERR_NONE && err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
        if (wrap_d && err_d == ERR_NONE && wrap_cnt_q != '1) begin
          wrap_cnt_q <= wrap_cnt_q + CNT_W'(1);
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_left  = out_left_q;
  assign bus.out_right = out_right_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_wrap  = out_wrap_q;
  assign err_cnt       = err_cnt_q;
  assign wrap_cnt      = wrap_cnt_q;
endmodule

// File: tb/tb_max2bitset_seq_checker.sv
// Bench for max2bitset_seq_checker: vector table plus scoreboard of expected results.
module tb_max2bitset_seq_checker;
  import max2bitset_pkg::*;

  localparam int unsigned BW = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          locked;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] wrap_cnt;

  max2bitset_seq_checker_if #(.BW_NUM(BW)) bus ();

  max2bitset_seq_checker #(
    .BW_NUM (BW),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .bus      (bus),
    .locked   (locked),
    .err_cnt  (err_cnt),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] left;
    logic [1:0] right;
    logic [1:0] err;
    logic       wrap;
  } res_t;

  typedef struct packed {
    logic [3:0] num;
    res_t       res;
  } vec_t;

  vec_t vecs [15];
  res_t sb [$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [3:0] num, input logic [1:0] l, input logic [1:0] r,
                              input logic [1:0] e, input logic w);
    vec_t v;
    v.num       = num;
    v.res.left  = l;
    v.res.right = r;
    v.res.err   = e;
    v.res.wrap  = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every retiring result is popped against the scoreboard in arrival order.
  always @(negedge clk) begin
    if (rst_b === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_result: got %0h with nothing expected",
                 {bus.out_left, bus.out_right, bus.out_err, bus.out_wrap});
      end else begin
        chk("result", 32'({bus.out_left, bus.out_right, bus.out_err, bus.out_wrap}),
            32'(sb.pop_front()));
      end
    end
  end

  task automatic put_word(input logic [3:0] num, input res_t e, output int waits);
    logic rdy;
    bus.in_valid = 1'b1;
    bus.in_num   = num;
    sb.push_back(e);
    waits = 0;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 20) begin
        chk("accept_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int w;
    for (int i = lo; i <= hi; i++) begin
      put_word(vecs[i].num, vecs[i].res, w);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && bus.out_valid === 1'b0) break;
      n++;
      if (n > 20) begin
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_b        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    sb.delete();
  endtask

  initial begin
    int w;
    vecs[0]  = mk(4'd3,  2'd1, 2'd0, 2'd0, 1'b0);
    vecs[1]  = mk(4'd5,  2'd2, 2'd0, 2'd0, 1'b0);
    vecs[2]  = mk(4'd6,  2'd2, 2'd1, 2'd0, 1'b0);
    vecs[3]  = mk(4'd9,  2'd3, 2'd0, 2'd0, 1'b0);
    vecs[4]  = mk(4'd10, 2'd3, 2'd1, 2'd0, 1'b0);
    vecs[5]  = mk(4'd12, 2'd3, 2'd2, 2'd0, 1'b1);
    vecs[6]  = mk(4'd3,  2'd1, 2'd0, 2'd0, 1'b0);
    vecs[7]  = mk(4'd3,  2'd1, 2'd0, 2'd0, 1'b0);
    vecs[8]  = mk(4'd5,  2'd2, 2'd0, 2'd0, 1'b0);
    vecs[9]  = mk(4'd9,  2'd3, 2'd0, 2'd2, 1'b0);
    vecs[10] = mk(4'd10, 2'd3, 2'd1, 2'd0, 1'b0);
    vecs[11] = mk(4'd3,  2'd1, 2'd0, 2'd2, 1'b0);
    vecs[12] = mk(4'd7,  2'd0, 2'd0, 2'd1, 1'b0);
    vecs[13] = mk(4'd5,  2'd2, 2'd0, 2'd2, 1'b0);
    vecs[14] = mk(4'd3,  2'd1, 2'd0, 2'd0, 1'b0);

    rst_b         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_result", 32'({bus.out_left, bus.out_right, bus.out_err, bus.out_wrap}), 32'd0);
    @(posedge clk);
    #1;

    // Full cycle of the sequence plus the wrap back to 3.
    run_vecs(0, 0);
    drain();
    chk("lock_first", 32'(locked), 32'd1);
    run_vecs(1, 6);
    drain();
    chk("seq_locked", 32'(locked), 32'd1);
    chk("seq_wrap_cnt", 32'(wrap_cnt), 32'd1);
    chk("seq_err_cnt", 32'(err_cnt), 32'd0);

    // Sequence error while tracking.
    do_reset();
    run_vecs(7, 10);
    drain();
    chk("seqerr_err_cnt", 32'(err_cnt), 32'd1);
    chk("seqerr_locked", 32'(locked), 32'd1);

    // Not-two-hot drops lock; out-of-order word in SYNC; relock on 3.
    run_vecs(11, 12);
    drain();
    chk("not2hot_locked", 32'(locked), 32'd0);
    chk("not2hot_err_cnt", 32'(err_cnt), 32'd3);
    run_vecs(13, 14);
    drain();
    chk("relock_locked", 32'(locked), 32'd1);
    chk("relock_err_cnt", 32'(err_cnt), 32'd4);
    chk("relock_wrap_cnt", 32'(wrap_cnt), 32'd0);

    // Backpressure: hold 5, stall 6 for three cycles, then stream.
    bus.out_ready = 1'b0;
    put_word(4'd5, res_t'({2'd2, 2'd0, 2'd0, 1'b0}), w);
    chk("bp_first_wait", 32'(w), 32'd0);
    fork
      put_word(4'd6, res_t'({2'd2, 2'd1, 2'd0, 1'b0}), w);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
          chk("bp_hold", 32'({bus.out_valid, bus.out_left, bus.out_right}), 32'b1_10_00);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    chk("bp_stall_waits", 32'(w), 32'd3);
    put_word(4'd9, res_t'({2'd3, 2'd0, 2'd0, 1'b0}), w);
    chk("bp_stream_9", 32'(w), 32'd0);
    put_word(4'd10, res_t'({2'd3, 2'd1, 2'd0, 1'b0}), w);
    chk("bp_stream_10", 32'(w), 32'd0);
    drain();
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while a result is held.
    bus.out_ready = 1'b0;
    put_word(4'd12, res_t'({2'd3, 2'd2, 2'd0, 1'b1}), w);
    @(negedge clk);
    chk("held_valid", 32'(bus.out_valid), 32'd1);
    chk("held_wrap_cnt", 32'(wrap_cnt), 32'd1);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_counters", 32'({err_cnt, wrap_cnt}), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      put_word(4'd0, res_t'({2'd0, 2'd0, 2'd1, 1'b0}), w);
      if (i == 254) chk("sat_reach", 32'(err_cnt), 32'd255);
    end
    drain();
    chk("sat_hold", 32'(err_cnt), 32'd255);
    chk("sat_locked", 32'(locked), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
